ps2_mouse_init_seq: RTL and testbench
=====================================

Name: ps2_mouse_init_seq

Overview:
- Sequencer that drives the PS/2 host-to-device transmitter through the mouse start-up handshake.
- Builds each 11-bit command frame, including start, odd parity and stop bits, and pulses the transmitter's send input.
- After each send, waits for the transmitter's ok/err and then for the device response bytes from the PS/2 receiver.
- Retries on NAK, transmit error or timeout. Sits between the top-level mouse controller and the sender/receiver pair.

Parameters:
- RETRIES, 3, maximum re-sends of one command before FAIL (1..15).
- TIMEOUT_CYCLES, 50000000, qzt_clk cycles allowed for each wait state (1 s at 50 MHz); 26-bit counter.
- CMD_RESET, 8'hFF, first command byte.
- CMD_ENABLE, 8'hF4, second command byte (enable data reporting).

Ports:
- qzt_clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  rising edge starts the sequence; ignored while busy.
- tx_frame  out  [0:10]  frame to sender. Bit 0 = start (0), bits 1..8 = command byte LSB first (tx_frame[1]=byte[0]), bit 9 = odd parity, bit 10 = stop (1).
- tx_send  out  1  one-cycle pulse requesting transmission of tx_frame.
- tx_ok  in  1  one-cycle pulse from sender: transmission finished.
- tx_err  in  1  sender error level, sampled on the tx_ok cycle.
- rx_valid  in  1  one-cycle pulse: rx_byte holds a received device byte.
- rx_byte  in  8  received byte.
- busy  out  1  high from the cycle after a start edge until DONE or FAIL.
- done  out  1  sticky; sequence completed. Cleared by reset or a new start.
- fail  out  1  sticky; retries exhausted. Cleared by reset or a new start.
- state  out  4  current state encoding, for inspection.

Behaviour:
- Reset values: tx_frame=11'b0_00000000_0_1, tx_send=0, busy=0, done=0, fail=0, state=IDLE(0); retry and timeout counters 0; command index 0.
- Parity: tx_frame[9] = ~^byte, so the total count of ones over byte and parity is odd. 0xFF gives parity 1; 0xF4 gives parity 0.
- States and transitions:
  - IDLE(0): on start rising edge (start_old=0, start=1), clear done/fail, set busy, set cmd index 0, set retry count 0, go to LOAD.
  - LOAD(1): tx_frame <= frame(cmd index: 0 -> CMD_RESET, 1 -> CMD_ENABLE). Next cycle go to SEND.
  - SEND(2): tx_send=1 for exactly this cycle; clear timeout counter; go to WAIT_OK.
  - WAIT_OK(3): on tx_ok, if tx_err=1 go to RETRY, else go to WAIT_ACK and clear timeout. rx_valid in this state is ignored.
  - WAIT_ACK(4), on rx_valid:
    - 0xFA: go to WAIT_BAT if cmd index 0, else NEXT.
    - 0xFE: go to RETRY.
    - any other byte: go to RETRY.
  - WAIT_BAT(5): on rx_valid, 0xAA goes to WAIT_ID; 0xFC or any other byte goes to RETRY.
  - WAIT_ID(6): any rx_valid byte (0x00 expected, value not checked) goes to NEXT.
  - NEXT(7): if cmd index 1, go to DONE; else cmd index++, retry count 0, go to LOAD.
  - RETRY(8): if retry count == RETRIES, go to FAIL; else retry count++ and go to LOAD.
  - DONE(9): done=1, busy=0, then go to IDLE. done stays high.
  - FAIL(10): fail=1, busy=0, then go to IDLE. fail stays high.
  - Unused encodings: go to IDLE with fail=1.
- Timeout: in states 3..6 the counter increments every cycle. When it reaches TIMEOUT_CYCLES-1 without the awaited event, go to RETRY. Event and timeout in the same cycle: the event wins. The counter clears on every state change.
- Simultaneous tx_ok and rx_valid in WAIT_OK: tx_ok is handled and the byte is dropped.
- Latency: start edge to first tx_send pulse is 3 cycles (IDLE, LOAD, SEND).
- Reset asserted mid-sequence returns everything to reset values on the next edge. tx_send is never high in the cycle after reset.
- start held high does not retrigger; a new rising edge is needed after returning to IDLE.

Test Plan:
- Nominal: start pulse; respond tx_ok (err=0), then 0xFA, 0xAA, 0x00; next tx_ok, then 0xFA. Require exactly 2 tx_send pulses, first frame 11'b0_11111111_1_1, second 11'b0_00101111_0_1; done=1, busy=0, state=0.
- NAK: on the first command reply 0xFE twice, then 0xFA/0xAA/0x00 and the nominal second command. Require 4 tx_send pulses total and done=1.
- Exhaustion: assert tx_err with every tx_ok. Require RETRIES+1=4 tx_send pulses of frame 0xFF, then fail=1, done=0, busy=0.
- Timeout: TIMEOUT_CYCLES=100; never pulse tx_ok. Require a re-send 100 cycles after each WAIT_OK entry, and fail=1 after 4 sends.
- Reset mid-op: assert reset for 1 cycle while in WAIT_BAT. Require all outputs at reset values the next cycle; a fresh start then completes the nominal sequence.
- Start while busy: pulse start during WAIT_ACK. Require no extra tx_send and sequence progress unaffected.

Source files
------------

// File: rtl/ps2_mouse_init_seq.sv
// ---------------------------------------------------------------------------
// ps2_mouse_init_seq
// Runs the PS/2 mouse start-up handshake through the host-to-device sender.
// It sends RESET (0xFF), expects ACK/BAT/ID, then sends ENABLE (0xF4) and
// expects ACK. A NAK, a transmit error or a timeout causes the current
// command to be re-sent, up to RETRIES times.
//
// Ports
//   qzt_clk   in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   rising edge starts the sequence (ignored while busy)
//   tx_frame  out  [0:10] start, byte LSB first, odd parity, stop
//   tx_send   out  one-cycle send request to the transmitter
//   tx_ok     in   one-cycle "transmission finished" from the transmitter
//   tx_err    in   transmitter error, sampled with tx_ok
//   rx_valid  in   one-cycle strobe, rx_byte holds a device byte
//   rx_byte   in   received device byte
//   busy      out  sequence in progress
//   done      out  sticky, sequence completed
//   fail      out  sticky, retries exhausted
//   state     out  current state encoding
// ---------------------------------------------------------------------------
module ps2_mouse_init_seq #(
    parameter int unsigned RETRIES        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter logic [7:0]  CMD_RESET      = 8'hFF,
    parameter logic [7:0]  CMD_ENABLE     = 8'hF4
) (
    input  logic        qzt_clk,
    input  logic        reset,
    input  logic        start,
    output logic [0:10] tx_frame,
    output logic        tx_send,
    input  logic        tx_ok,
    input  logic        tx_err,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [3:0]  state
);

    localparam int unsigned TMO_W   = 26;
    localparam int unsigned RETRY_W = 4;

    localparam logic [0:10]      FRAME_IDLE = 11'b0_00000000_0_1;
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(RETRIES);

    localparam logic [7:0] RSP_ACK = 8'hFA;
    localparam logic [7:0] RSP_BAT = 8'hAA;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_SEND     = 4'd2,
        ST_WAIT_OK  = 4'd3,
        ST_WAIT_ACK = 4'd4,
        ST_WAIT_BAT = 4'd5,
        ST_WAIT_ID  = 4'd6,
        ST_NEXT     = 4'd7,
        ST_RETRY    = 4'd8,
        ST_DONE     = 4'd9,
        ST_FAIL     = 4'd10
    } state_t;

    state_t             r_state;
    logic [0:10]        r_frame;
    logic               r_send;
    logic               r_busy;
    logic               r_done;
    logic               r_fail;
    logic               r_cmd_idx;
    logic [RETRY_W-1:0] r_retry;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_start_old;

    state_t             w_state_nxt;
    logic [0:10]        w_frame_nxt;
    logic               w_send_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_fail_nxt;
    logic               w_cmd_idx_nxt;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic               w_start_edge;
    logic               w_waiting;
    logic               w_tmo_hit;

    // Frame layout: start(0), data LSB first, odd parity, stop(1).
    function automatic logic [0:10] build_frame(input logic [7:0] b);
        logic [0:10] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[1 + i] = b[i];
        end
        f[9]  = ~^b;
        f[10] = 1'b1;
        return f;
    endfunction

    assign w_start_edge = start & ~r_start_old;
    assign w_waiting    = (r_state == ST_WAIT_OK)  || (r_state == ST_WAIT_ACK) ||
                          (r_state == ST_WAIT_BAT) || (r_state == ST_WAIT_ID);
    assign w_tmo_hit    = (r_tmo == TMO_LAST);

    // State and output registers.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_frame     <= FRAME_IDLE;
            r_send      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_cmd_idx   <= 1'b0;
            r_retry     <= '0;
            r_tmo       <= '0;
            // Track start during reset so a level held across reset is not an edge.
            r_start_old <= start;
        end else begin
            r_state     <= w_state_nxt;
            r_frame     <= w_frame_nxt;
            r_send      <= w_send_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_fail      <= w_fail_nxt;
            r_cmd_idx   <= w_cmd_idx_nxt;
            r_retry     <= w_retry_nxt;
            r_tmo       <= w_tmo_nxt;
            r_start_old <= start;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_nxt   = r_frame;
        w_send_nxt    = 1'b0;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_fail_nxt    = r_fail;
        w_cmd_idx_nxt = r_cmd_idx;
        w_retry_nxt   = r_retry;
        w_tmo_nxt     = r_tmo;

        if (w_waiting) begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_done_nxt    = 1'b0;
                    w_fail_nxt    = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_cmd_idx_nxt = 1'b0;
                    w_retry_nxt   = '0;
                    w_state_nxt   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_frame_nxt = build_frame(r_cmd_idx ? CMD_ENABLE : CMD_RESET);
                // Registered, so the pulse is high exactly while in SEND.
                w_send_nxt  = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                w_state_nxt = ST_WAIT_OK;
            end
            ST_WAIT_OK: begin
                // A byte arriving here is dropped; tx_ok takes priority.
                if (tx_ok) begin
                    w_state_nxt = tx_err ? ST_RETRY : ST_WAIT_ACK;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_RETRY;
                end
            end
            ST_WAIT_ACK: begin
                if (rx_valid) begin
                    if (rx_byte == RSP_ACK) begin
                        w_state_nxt = r_cmd_idx ? ST_NEXT : ST_WAIT_BAT;
                    end else begin
                        w_state_nxt = ST_RETRY;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_RETRY;
                end
            end
            ST_WAIT_BAT: begin
                if (rx_valid) begin
                    w_state_nxt = (rx_byte == RSP_BAT) ? ST_WAIT_ID : ST_RETRY;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_RETRY;
                end
            end
            ST_WAIT_ID: begin
                // Device ID value is not checked.
                if (rx_valid) begin
                    w_state_nxt = ST_NEXT;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_RETRY;
                end
            end
            ST_NEXT: begin
                if (r_cmd_idx) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cmd_idx_nxt = 1'b1;
                    w_retry_nxt   = '0;
                    w_state_nxt   = ST_LOAD;
                end
            end
            ST_RETRY: begin
                if (r_retry == RETRY_MAX) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_retry_nxt = r_retry + RETRY_W'(1);
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            ST_FAIL: begin
                w_fail_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_fail_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Each wait state gets a fresh timeout window.
        if (w_state_nxt != r_state) begin
            w_tmo_nxt = '0;
        end
    end

    assign tx_frame = r_frame;
    assign tx_send  = r_send;
    assign busy     = r_busy;
    assign done     = r_done;
    assign fail     = r_fail;
    assign state    = r_state;

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_init_seq
// Directed bench for ps2_mouse_init_seq. Expected frames are queued when the
// bench decides a send must happen and are popped when tx_send is seen.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_init_seq;

    localparam int unsigned TMO = 100;

    localparam logic [10:0] FRAME_RST = 11'b0_00000000_0_1;
    localparam logic [10:0] FRAME_FF  = 11'b0_11111111_1_1;
    localparam logic [10:0] FRAME_F4  = 11'b0_00101111_0_1;

    localparam logic [3:0] S_IDLE = 4'd0, S_LOAD = 4'd1, S_SEND = 4'd2,
                           S_WOK = 4'd3, S_WACK = 4'd4, S_WBAT = 4'd5,
                           S_WID = 4'd6, S_RETRY = 4'd8;

    logic        qzt_clk = 1'b0;
    logic        reset;
    logic        start;
    logic [0:10] tx_frame;
    logic        tx_send;
    logic        tx_ok;
    logic        tx_err;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        busy;
    logic        done;
    logic        fail;
    logic [3:0]  state;

    int errors = 0;
    int checks = 0;
    int sends  = 0;
    int cyc    = 0;
    logic [10:0] sb[$];

    ps2_mouse_init_seq #(
        .RETRIES        (3),
        .TIMEOUT_CYCLES (TMO),
        .CMD_RESET      (8'hFF),
        .CMD_ENABLE     (8'hF4)
    ) dut (
        .qzt_clk  (qzt_clk),
        .reset    (reset),
        .start    (start),
        .tx_frame (tx_frame),
        .tx_send  (tx_send),
        .tx_ok    (tx_ok),
        .tx_err   (tx_err),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .state    (state)
    );

    always #5 qzt_clk = ~qzt_clk;

    always @(posedge qzt_clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every send must match the oldest queued frame.
    always @(negedge qzt_clk) begin
        if (tx_send === 1'b1) begin
            sends++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected_send: observed=0x%0h expected=none", 32'(tx_frame));
            end
            if (sb.size() > 0) begin
                check("sb_frame", 32'(tx_frame), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge qzt_clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic pulse_ok(input logic err);
        tx_ok = 1'b1; tx_err = err;
        tick();
        tx_ok = 1'b0; tx_err = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1; rx_byte = b;
        tick();
        rx_valid = 1'b0; rx_byte = 8'h00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // From WAIT_ACK of command 0: ACK, BAT, ID, then the whole ENABLE command.
    task automatic finish_nominal();
        send_byte(8'hFA);
        wait_state(S_WBAT, 10, "wait_bat");
        send_byte(8'hAA);
        wait_state(S_WID, 10, "wait_id");
        sb.push_back(FRAME_F4);
        send_byte(8'h00);
        wait_state(S_WOK, 10, "wait_ok_cmd1");
        pulse_ok(1'b0);
        wait_state(S_WACK, 10, "wait_ack_cmd1");
        send_byte(8'hFA);
        wait_state(S_IDLE, 10, "wait_idle_done");
    endtask

    task automatic check_end(input string tag, input int exp_sends, input logic d, input logic f);
        check({tag, "_sends"}, 32'(sends), 32'(exp_sends));
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_fail"}, 32'(fail), 32'(f));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_state"}, 32'(state), 32'(S_IDLE));
    endtask

    task automatic run_nominal(input string tag);
        sends = 0;
        sb.push_back(FRAME_FF);
        pulse_start();
        check({tag, "_lat_load"}, 32'(state), 32'(S_LOAD));
        check({tag, "_busy_up"}, 32'(busy), 32'(1));
        tick();
        check({tag, "_lat_send"}, 32'(tx_send), 32'(1));
        check({tag, "_lat_state"}, 32'(state), 32'(S_SEND));
        wait_state(S_WOK, 10, "wait_ok_cmd0");
        pulse_ok(1'b0);
        wait_state(S_WACK, 10, "wait_ack_cmd0");
        finish_nominal();
        check_end(tag, 2, 1'b1, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; tx_ok = 1'b0; tx_err = 1'b0;
        rx_valid = 1'b0; rx_byte = 8'h00;
        repeat (3) tick();
        check("rst_frame", 32'(tx_frame), 32'(FRAME_RST));
        check("rst_send", 32'(tx_send), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_state", 32'(state), 32'(S_IDLE));
        reset = 1'b0;
        repeat (2) tick();

        // Nominal sequence.
        run_nominal("nom");

        // Two NAKs on the RESET command, then success.
        sends = 0;
        sb.push_back(FRAME_FF);
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            wait_state(S_WOK, 10, "nak_wait_ok");
            pulse_ok(1'b0);
            wait_state(S_WACK, 10, "nak_wait_ack");
            sb.push_back(FRAME_FF);
            send_byte(8'hFE);
        end
        wait_state(S_WOK, 10, "nak_wait_ok3");
        pulse_ok(1'b0);
        wait_state(S_WACK, 10, "nak_wait_ack3");
        finish_nominal();
        check_end("nak", 4, 1'b1, 1'b0);

        // Transmit error on every attempt exhausts retries.
        sends = 0;
        repeat (4) sb.push_back(FRAME_FF);
        pulse_start();
        check("exh_done_clr", 32'(done), 32'(0));
        for (int k = 0; k < 4; k++) begin
            wait_state(S_WOK, 10, "exh_wait_ok");
            pulse_ok(1'b1);
        end
        wait_state(S_IDLE, 10, "exh_wait_idle");
        check_end("exh", 4, 1'b0, 1'b1);

        // No tx_ok at all: each WAIT_OK times out after TMO cycles.
        sends = 0;
        repeat (4) sb.push_back(FRAME_FF);
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            int t0;
            wait_state(S_WOK, 10, "tmo_wait_ok");
            t0 = cyc;
            wait_state(S_RETRY, 2 * TMO, "tmo_wait_retry");
            check("tmo_interval", 32'(cyc - t0), 32'(TMO));
        end
        wait_state(S_IDLE, 10, "tmo_wait_idle");
        check_end("tmo", 4, 1'b0, 1'b1);

        // Reset in WAIT_BAT, then a fresh complete sequence.
        sends = 0;
        sb.push_back(FRAME_FF);
        pulse_start();
        wait_state(S_WOK, 10, "rmid_wait_ok");
        pulse_ok(1'b0);
        wait_state(S_WACK, 10, "rmid_wait_ack");
        send_byte(8'hFA);
        wait_state(S_WBAT, 10, "rmid_wait_bat");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmid_frame", 32'(tx_frame), 32'(FRAME_RST));
        check("rmid_send", 32'(tx_send), 32'(0));
        check("rmid_busy", 32'(busy), 32'(0));
        check("rmid_done", 32'(done), 32'(0));
        check("rmid_fail", 32'(fail), 32'(0));
        check("rmid_state", 32'(state), 32'(S_IDLE));
        tick();
        check("rmid_send_after", 32'(tx_send), 32'(0));
        check("rmid_state_after", 32'(state), 32'(S_IDLE));
        run_nominal("rnom");

        // Start edge while busy is ignored.
        sends = 0;
        sb.push_back(FRAME_FF);
        pulse_start();
        wait_state(S_WOK, 10, "sb_wait_ok");
        pulse_ok(1'b0);
        wait_state(S_WACK, 10, "sb_wait_ack");
        pulse_start();
        tick();
        check("busy_start_state", 32'(state), 32'(S_WACK));
        check("busy_start_busy", 32'(busy), 32'(1));
        finish_nominal();
        check_end("bstart", 2, 1'b1, 1'b0);

        repeat (5) tick();
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
